wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and architectural register file of the five-stage core. Sits directly downstream of the stage-4 (MEM/WB) pipeline register: consumes its registered ALU result, load data, destination fields, link address and writeback controls; selects the write data and destination; commits to a 32×32 register file. Serves the decode stage's two read ports, which include same-cycle writeback bypass, plus a debug read port and a retired-write counter.

## Interface
- `IM_ADDR_BIT`, from Core.vh: width of `pc_4`, a word index.
- `MUX_RF_DATAW_BIT`, from Core.vh, ≥2: width of the data-select code.
- `MUX_RF_REQW_BIT`, from Core.vh, ≥2: width of the destination-select code.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: writeback enable. Low means stall: no commit and no counter update.
- `alu_data_res` in 32: ALU result from stage 4.
- `datamem_data` in 32: load data from stage 4.
- `rd` in 5: rd field from stage 4.
- `rt` in 5: rt field from stage 4.
- `pc_4` in IM_ADDR_BIT: word index of the instruction after the current one.
- `mux_regfile_data_w` in MUX_RF_DATAW_BIT: selects the write data. 0 = ALU result, 1 = load data, 2 = link value, other codes = ALU result.
- `mux_regfile_req_w` in MUX_RF_REQW_BIT: selects the destination. 0 = rd, 1 = rt, 2 = 31, other codes = rd.
- `regfile_w_en` in 1: write request from stage 4.
- `rs_addr`, `rt_addr` in 5: decode-stage read addresses.
- `rs_data`, `rt_data` out 32: decode-stage read data.
- `dbg_addr` in 5: debug read address; this port has no bypass.
- `dbg_data` out 32: debug read data.
- `wb_data` out 32: selected write data, for forwarding units.
- `wb_addr` out 5: selected destination.
- `wb_commit` out 1: high when a commit happens at the next edge.
- `retire_cnt` out 32: number of committed writes.

## Operation
- Link value = zero-extend(`pc_4`) shifted left by 2, giving a byte address, truncated to 32 bits.
- `wb_data` and `wb_addr` are combinational functions of the selects above.
- `wb_commit` = `en` & `regfile_w_en` & (`wb_addr` ≠ 0).
- At a rising edge with `wb_commit` high:
  - register[`wb_addr`] ← `wb_data`;
  - `retire_cnt` ← `retire_cnt` + 1, modulo 2^32, so 0xFFFFFFFF wraps to 0.
- Register 0 is never written and always reads 0, including through the bypass path.
- Read port X ∈ {rs, rt}:
  - if `X_addr` = 0, output 0;
  - else if `wb_commit` is high and `X_addr` = `wb_addr`, output `wb_data` (write-through bypass);
  - else output register[`X_addr`].
- `dbg_data` = register[`dbg_addr`] with no bypass; it shows the stored value only.
- Writes with `en` low or `regfile_w_en` low leave all state unchanged. Inputs are not held internally: a stalled write is committed only if stage 4 still presents it once `en` returns high.

## Timing
- Asserting `rst` asynchronously sets all 32 registers and `retire_cnt` to 0.
  - While `rst` is high: `rs_data` = `rt_data` = `dbg_data` = 0; `retire_cnt` = 0; `wb_commit` = 0, forced low by reset.
  - `wb_data` and `wb_addr` stay combinational from the inputs.
- Reset deasserted between edges: the first commit is possible at the next rising edge.
- Reset asserted mid-operation: a write pending at that edge is lost and the register reads 0.
- Commit latency is one edge. Through `rs`/`rt`, write data is visible in the same cycle via the bypass. Through `dbg`, it is visible in the cycle after the edge.
- All read paths are purely combinational from addresses and state, with no read latency.
- If both read ports and the write address are the same register, both read ports bypass.

## Test plan
- Reset: write 0x1234 to r5, then pulse `rst` between edges → `dbg_data`(r5) = 0 immediately, `retire_cnt` = 0.
- Data and destination selects, `pc_4` = 0x40:
  - code 2 with `mux_regfile_req_w` = 2 → r31 = 0x100;
  - code 1 with `rt` = 7, `datamem_data` = 0xDEADBEEF → r7 = 0xDEADBEEF;
  - code 0 with `rd` = 3, `alu_data_res` = 0x55 → r3 = 0x55;
  - `retire_cnt` = 3.
- Bypass: r9 holds 0x11; in the same cycle write 0x22 to r9 with `rs_addr` = `rt_addr` = 9 → `rs_data` = `rt_data` = 0x22 and `dbg_data` = 0x11 before the edge, `dbg_data` = 0x22 after it.
- r0 protection: `regfile_w_en` = 1, `wb_addr` = 0, data 0xFFFFFFFF, `rs_addr` = 0 → `rs_data` = 0, `wb_commit` = 0, `retire_cnt` unchanged.
- Stall: `en` = 0 with a valid write of 0x77 to r4 → r4 unchanged, no bypass, counter unchanged. Raise `en` → committed at the next edge.
- Counter wrap: preload via 2^32−1 commits (or a forced counter value) → the next commit makes `retire_cnt` = 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage: selects write data/destination from the MEM/WB register and
// commits into a 32x32 register file with bypassed decode reads, a debug port and a retire counter.
module wb_regfile #(
  parameter int unsigned IM_ADDR_BIT      = 30,
  parameter int unsigned MUX_RF_DATAW_BIT = 2,
  parameter int unsigned MUX_RF_REQW_BIT  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [31:0]                 alu_data_res,
  input  logic [31:0]                 datamem_data,
  input  logic [4:0]                  rd,
  input  logic [4:0]                  rt,
  input  logic [IM_ADDR_BIT-1:0]      pc_4,
  input  logic [MUX_RF_DATAW_BIT-1:0] mux_regfile_data_w,
  input  logic [MUX_RF_REQW_BIT-1:0]  mux_regfile_req_w,
  input  logic                        regfile_w_en,
  input  logic [4:0]                  rs_addr,
  input  logic [4:0]                  rt_addr,
  output logic [31:0]                 rs_data,
  output logic [31:0]                 rt_data,
  input  logic [4:0]                  dbg_addr,
  output logic [31:0]                 dbg_data,
  output logic [31:0]                 wb_data,
  output logic [4:0]                  wb_addr,
  output logic                        wb_commit,
  output logic [31:0]                 retire_cnt
);

  typedef enum logic [MUX_RF_DATAW_BIT-1:0] {
    DATA_ALU  = MUX_RF_DATAW_BIT'(0),
    DATA_MEM  = MUX_RF_DATAW_BIT'(1),
    DATA_LINK = MUX_RF_DATAW_BIT'(2)
  } data_sel_e;

  typedef enum logic [MUX_RF_REQW_BIT-1:0] {
    REQ_RD = MUX_RF_REQW_BIT'(0),
    REQ_RT = MUX_RF_REQW_BIT'(1),
    REQ_RA = MUX_RF_REQW_BIT'(2)
  } req_sel_e;

  // Wide enough to hold pc_4 << 2 before truncating to a 32-bit byte address.
  localparam int unsigned LINK_W = (IM_ADDR_BIT + 2 > 32) ? IM_ADDR_BIT + 2 : 32;

  logic [LINK_W-1:0] link_wide;
  logic [31:0]       link_val;
  logic [31:0]       regs [32];

  assign link_wide = {{(LINK_W - IM_ADDR_BIT){1'b0}}, pc_4} << 2;
  assign link_val  = link_wide[31:0];

  always_comb begin
    wb_data = alu_data_res;
    case (mux_regfile_data_w)
      DATA_MEM:  wb_data = datamem_data;
      DATA_LINK: wb_data = link_val;
      default:   wb_data = alu_data_res;
    endcase
  end

  always_comb begin
    wb_addr = rd;
    case (mux_regfile_req_w)
      REQ_RT:  wb_addr = rt;
      REQ_RA:  wb_addr = 5'd31;
      default: wb_addr = rd;
    endcase
  end

  // Reset gates the commit so the bypass is also silent while rst is high.
  assign wb_commit = en & regfile_w_en & (wb_addr != 5'd0) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      retire_cnt <= '0;
    end else if (wb_commit) begin
      regs[wb_addr] <= wb_data;
      retire_cnt    <= retire_cnt + 32'd1;
    end
  end

  always_comb begin
    rs_data = regs[rs_addr];
    if (rs_addr == 5'd0) begin
      rs_data = '0;
    end else if (wb_commit && (rs_addr == wb_addr)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (rt_addr == 5'd0) begin
      rt_data = '0;
    end else if (wb_commit && (rt_addr == wb_addr)) begin
      rt_data = wb_data;
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, selects, bypass, r0 protection, stall and counter wrap.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] alu_data_res;
  logic [31:0] datamem_data;
  logic [4:0]  rd;
  logic [4:0]  rt;
  logic [29:0] pc_4;
  logic [1:0]  mux_regfile_data_w;
  logic [1:0]  mux_regfile_req_w;
  logic        regfile_w_en;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_commit;
  logic [31:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  wb_regfile #(
    .IM_ADDR_BIT(30),
    .MUX_RF_DATAW_BIT(2),
    .MUX_RF_REQW_BIT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .alu_data_res(alu_data_res),
    .datamem_data(datamem_data),
    .rd(rd),
    .rt(rt),
    .pc_4(pc_4),
    .mux_regfile_data_w(mux_regfile_data_w),
    .mux_regfile_req_w(mux_regfile_req_w),
    .regfile_w_en(regfile_w_en),
    .rs_addr(rs_addr),
    .rt_addr(rt_addr),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .wb_data(wb_data),
    .wb_addr(wb_addr),
    .wb_commit(wb_commit),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] dsel, input logic [1:0] rsel, input logic [4:0] d,
                       input logic [4:0] t, input logic [31:0] alu, input logic [31:0] mem);
    mux_regfile_data_w = dsel;
    mux_regfile_req_w  = rsel;
    rd                 = d;
    rt                 = t;
    alu_data_res       = alu;
    datamem_data       = mem;
    regfile_w_en       = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; pc_4 = '0; rs_addr = 5'd5; rt_addr = 5'd5; dbg_addr = 5'd5;
    drive(2'd0, 2'd0, 5'd5, 5'd0, 32'h1234, 32'h0);
    #2;
    n_cmp++; if (wb_commit !== 1'b0) begin n_bad++; $display("FAIL rst_commit: got %b want 0", wb_commit); end
    n_cmp++; if (rs_data !== 32'h0) begin n_bad++; $display("FAIL rst_rs: got %h want 0", rs_data); end
    n_cmp++; if (retire_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_cnt: got %h want 0", retire_cnt); end
    n_cmp++; if (wb_data !== 32'h1234) begin n_bad++; $display("FAIL rst_wbdata: got %h want 1234", wb_data); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (dbg_data !== 32'h1234) begin n_bad++; $display("FAIL r5_write: got %h want 1234", dbg_data); end
    n_cmp++; if (retire_cnt !== 32'd1) begin n_bad++; $display("FAIL r5_cnt: got %h want 1", retire_cnt); end
    regfile_w_en = 1'b0;
    @(negedge clk); #1; rst = 1'b1; #1;
    n_cmp++; if (dbg_data !== 32'h0) begin n_bad++; $display("FAIL rst_async_r5: got %h want 0", dbg_data); end
    n_cmp++; if (retire_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_async_cnt: got %h want 0", retire_cnt); end
    // write pending at an edge while reset is held is lost
    drive(2'd0, 2'd0, 5'd6, 5'd0, 32'h66, 32'h0); dbg_addr = 5'd6;
    @(posedge clk); #1;
    n_cmp++; if (dbg_data !== 32'h0) begin n_bad++; $display("FAIL rst_lost_r6: got %h want 0", dbg_data); end
    regfile_w_en = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_selects;
    @(negedge clk);
    pc_4 = 30'h40; dbg_addr = 5'd31;
    drive(2'd2, 2'd2, 5'd1, 5'd2, 32'hAAAA, 32'hBBBB);
    #1;
    n_cmp++; if (wb_data !== 32'h100) begin n_bad++; $display("FAIL link_data: got %h want 100", wb_data); end
    n_cmp++; if (wb_addr !== 5'd31) begin n_bad++; $display("FAIL link_addr: got %0d want 31", wb_addr); end
    @(posedge clk); #1;
    n_cmp++; if (dbg_data !== 32'h100) begin n_bad++; $display("FAIL r31: got %h want 100", dbg_data); end
    @(negedge clk);
    dbg_addr = 5'd7;
    drive(2'd1, 2'd1, 5'd1, 5'd7, 32'hAAAA, 32'hDEADBEEF);
    @(posedge clk); #1;
    n_cmp++; if (dbg_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL r7_load: got %h want deadbeef", dbg_data); end
    @(negedge clk);
    dbg_addr = 5'd3;
    drive(2'd0, 2'd0, 5'd3, 5'd7, 32'h55, 32'hDEADBEEF);
    @(posedge clk); #1;
    n_cmp++; if (dbg_data !== 32'h55) begin n_bad++; $display("FAIL r3_alu: got %h want 55", dbg_data); end
    n_cmp++; if (retire_cnt !== 32'd3) begin n_bad++; $display("FAIL sel_cnt: got %h want 3", retire_cnt); end
    @(negedge clk);
    regfile_w_en = 1'b0;
    drive(2'd3, 2'd3, 5'd12, 5'd13, 32'h99, 32'h88); regfile_w_en = 1'b0;
    #1;
    n_cmp++; if (wb_data !== 32'h99) begin n_bad++; $display("FAIL code3_data: got %h want 99", wb_data); end
    n_cmp++; if (wb_addr !== 5'd12) begin n_bad++; $display("FAIL code3_addr: got %0d want 12", wb_addr); end
    n_cmp++; if (wb_commit !== 1'b0) begin n_bad++; $display("FAIL nowen_commit: got %b want 0", wb_commit); end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    drive(2'd0, 2'd0, 5'd9, 5'd0, 32'h11, 32'h0);
    @(negedge clk);
    drive(2'd0, 2'd0, 5'd9, 5'd0, 32'h22, 32'h0);
    rs_addr = 5'd9; rt_addr = 5'd9; dbg_addr = 5'd9;
    #1;
    n_cmp++; if (rs_data !== 32'h22) begin n_bad++; $display("FAIL byp_rs: got %h want 22", rs_data); end
    n_cmp++; if (rt_data !== 32'h22) begin n_bad++; $display("FAIL byp_rt: got %h want 22", rt_data); end
    n_cmp++; if (dbg_data !== 32'h11) begin n_bad++; $display("FAIL byp_dbg_pre: got %h want 11", dbg_data); end
    @(posedge clk); #1;
    n_cmp++; if (dbg_data !== 32'h22) begin n_bad++; $display("FAIL byp_dbg_post: got %h want 22", dbg_data); end
    n_cmp++; if (retire_cnt !== 32'd5) begin n_bad++; $display("FAIL byp_cnt: got %h want 5", retire_cnt); end
  endtask

  task automatic test_r0;
    @(negedge clk);
    drive(2'd0, 2'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0);
    rs_addr = 5'd0; dbg_addr = 5'd0;
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_bad++; $display("FAIL r0_rs: got %h want 0", rs_data); end
    n_cmp++; if (wb_commit !== 1'b0) begin n_bad++; $display("FAIL r0_commit: got %b want 0", wb_commit); end
    @(posedge clk); #1;
    n_cmp++; if (dbg_data !== 32'h0) begin n_bad++; $display("FAIL r0_dbg: got %h want 0", dbg_data); end
    n_cmp++; if (retire_cnt !== 32'd5) begin n_bad++; $display("FAIL r0_cnt: got %h want 5", retire_cnt); end
  endtask

  task automatic test_stall;
    @(negedge clk);
    en = 1'b0;
    drive(2'd0, 2'd0, 5'd4, 5'd0, 32'h77, 32'h0);
    rs_addr = 5'd4; dbg_addr = 5'd4;
    #1;
    n_cmp++; if (wb_commit !== 1'b0) begin n_bad++; $display("FAIL stall_commit: got %b want 0", wb_commit); end
    n_cmp++; if (rs_data !== 32'h0) begin n_bad++; $display("FAIL stall_rs: got %h want 0", rs_data); end
    @(posedge clk); #1;
    n_cmp++; if (dbg_data !== 32'h0) begin n_bad++; $display("FAIL stall_r4: got %h want 0", dbg_data); end
    n_cmp++; if (retire_cnt !== 32'd5) begin n_bad++; $display("FAIL stall_cnt: got %h want 5", retire_cnt); end
    @(negedge clk);
    en = 1'b1;
    #1;
    n_cmp++; if (rs_data !== 32'h77) begin n_bad++; $display("FAIL unstall_rs: got %h want 77", rs_data); end
    @(posedge clk); #1;
    n_cmp++; if (dbg_data !== 32'h77) begin n_bad++; $display("FAIL unstall_r4: got %h want 77", dbg_data); end
    n_cmp++; if (retire_cnt !== 32'd6) begin n_bad++; $display("FAIL unstall_cnt: got %h want 6", retire_cnt); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    regfile_w_en = 1'b0;
    force dut.retire_cnt = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt;
    #1;
    n_cmp++; if (retire_cnt !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL wrap_pre: got %h want ffffffff", retire_cnt); end
    drive(2'd0, 2'd0, 5'd10, 5'd0, 32'hA5, 32'h0);
    dbg_addr = 5'd10;
    @(posedge clk); #1;
    n_cmp++; if (retire_cnt !== 32'h0) begin n_bad++; $display("FAIL wrap_cnt: got %h want 0", retire_cnt); end
    n_cmp++; if (dbg_data !== 32'hA5) begin n_bad++; $display("FAIL wrap_r10: got %h want a5", dbg_data); end
    regfile_w_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_selects();
    test_bypass();
    test_r0();
    test_stall();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
